// File: rtl/garage_motor_driver.sv
// Motor bridge driver: braked dead-time around every energise/reversal, PWM
// soft-start ramp, limit overrun cut, travel timeout and sticky fault.
module garage_motor_driver #(
  parameter int DEAD_TIME = 50,
  parameter int RAMP_STEP = 1000,
  parameter int PWM_BITS  = 4,
  parameter int TIMEOUT   = 1500000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       UP_M,
  input  logic       DN_M,
  input  logic       UP_Max,
  input  logic       DN_Max,
  input  logic       FAULT_CLR,
  output logic       MOT_EN,
  output logic       MOT_DIR,
  output logic       BRAKE,
  output logic       FAULT,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BRAKE = 3'd1;
  localparam logic [2:0] S_RAMP  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam int DW   = $clog2(DEAD_TIME + 1);
  localparam int SW   = $clog2(RAMP_STEP + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int FULL = 1 << PWM_BITS;

  localparam logic [DW-1:0]     DEAD_LOAD = DW'(DEAD_TIME - 1);
  localparam logic [SW-1:0]     STEP_LAST = SW'(RAMP_STEP - 1);
  localparam logic [TW-1:0]     TRAV_LAST = TW'(TIMEOUT - 1);
  localparam logic [PWM_BITS:0] LAST_DUTY = (PWM_BITS + 1)'(FULL - 1);

  logic [2:0]          state;
  logic [DW-1:0]       dead_cnt;
  logic [SW-1:0]       step_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS:0]   duty;
  logic [TW-1:0]       travel_cnt;
  logic                dir;

  logic illegal, up_ok, dn_ok, stop_travel, step_done, timed_out;

  assign illegal   = UP_M & DN_M;
  assign up_ok     = UP_M & ~DN_M & ~UP_Max;
  assign dn_ok     = DN_M & ~UP_M & ~DN_Max;
  // One test covers command drop, reversal request and overrun of the travel limit.
  assign stop_travel = dir ? ~up_ok : ~dn_ok;
  assign step_done   = (step_cnt == STEP_LAST);
  assign timed_out   = (travel_cnt == TRAV_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      dead_cnt   <= '0;
      step_cnt   <= '0;
      pwm_cnt    <= '0;
      duty       <= '0;
      travel_cnt <= '0;
      dir        <= 1'b0;
    end else if (illegal) begin
      state <= S_FAULT;
      duty  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (up_ok | dn_ok) begin
            state    <= S_BRAKE;
            dead_cnt <= DEAD_LOAD;
          end
        end
        S_BRAKE: begin
          if (dead_cnt == '0) begin
            if (up_ok | dn_ok) begin
              state      <= S_RAMP;
              dir        <= up_ok;
              duty       <= '0;
              pwm_cnt    <= '0;
              step_cnt   <= '0;
              travel_cnt <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            dead_cnt <= dead_cnt - 1'b1;
          end
        end
        S_RAMP, S_RUN: begin
          // Stopping takes precedence over the timeout on the same edge.
          if (stop_travel) begin
            state    <= S_BRAKE;
            dead_cnt <= DEAD_LOAD;
            duty     <= '0;
          end else if (timed_out) begin
            state <= S_FAULT;
            duty  <= '0;
          end else begin
            travel_cnt <= travel_cnt + 1'b1;
            pwm_cnt    <= pwm_cnt + 1'b1;
            if (state == S_RAMP) begin
              if (step_done) begin
                step_cnt <= '0;
                duty     <= duty + 1'b1;
                if (duty == LAST_DUTY) state <= S_RUN;
              end else begin
                step_cnt <= step_cnt + 1'b1;
              end
            end
          end
        end
        S_FAULT: begin
          if (FAULT_CLR & ~UP_M & ~DN_M) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    MOT_EN = 1'b0;
    BRAKE  = 1'b1;
    case (state)
      S_RAMP: begin
        BRAKE  = 1'b0;
        MOT_EN = ({1'b0, pwm_cnt} < duty);
      end
      S_RUN: begin
        BRAKE  = 1'b0;
        MOT_EN = 1'b1;
      end
      default: ;
    endcase
  end

  assign FAULT     = (state == S_FAULT);
  assign MOT_DIR   = dir;
  assign dbg_state = state;

endmodule

// File: tb/tb_garage_motor_driver.sv
// Directed bench for garage_motor_driver: phase/age behavioural model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_garage_motor_driver;

  localparam int DEAD_TIME = 4;
  localparam int RAMP_STEP = 2;
  localparam int PWM_BITS  = 3;
  localparam int TIMEOUT   = 100;
  localparam int FULL      = 1 << PWM_BITS;

  localparam int P_IDLE  = 0;
  localparam int P_BRAKE = 1;
  localparam int P_RAMP  = 2;
  localparam int P_RUN   = 3;
  localparam int P_FAULT = 4;

  logic       clk = 1'b0;
  logic       rst, up_m, dn_m, up_max, dn_max, fault_clr;
  logic       mot_en, mot_dir, brake, fault;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;
  int en_count;

  int m_phase, m_age, m_travel;
  bit m_dir;
  bit m_valid = 1'b0;

  garage_motor_driver #(
    .DEAD_TIME(DEAD_TIME),
    .RAMP_STEP(RAMP_STEP),
    .PWM_BITS (PWM_BITS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .UP_M     (up_m),
    .DN_M     (dn_m),
    .UP_Max   (up_max),
    .DN_Max   (dn_max),
    .FAULT_CLR(fault_clr),
    .MOT_EN   (mot_en),
    .MOT_DIR  (mot_dir),
    .BRAKE    (brake),
    .FAULT    (fault),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Model: phase plus cycles spent in it, and travel cycles since ramp entry.
  always @(posedge clk) begin : model_b
    int nph, nage, ntrav;
    bit ndir, up_ok, dn_ok, keep;
    if (rst) begin
      m_phase  <= P_IDLE;
      m_age    <= 0;
      m_travel <= 0;
      m_dir    <= 1'b0;
      m_valid  <= 1'b1;
    end else if (m_valid) begin
      up_ok = up_m && !dn_m && !up_max;
      dn_ok = dn_m && !up_m && !dn_max;
      nph   = m_phase;
      ndir  = m_dir;
      if (up_m && dn_m) nph = P_FAULT;
      else begin
        case (m_phase)
          P_IDLE: if (up_ok || dn_ok) nph = P_BRAKE;
          P_BRAKE: begin
            if (m_age == DEAD_TIME - 1) begin
              if (up_ok || dn_ok) begin
                nph  = P_RAMP;
                ndir = up_ok;
              end else nph = P_IDLE;
            end
          end
          P_RAMP, P_RUN: begin
            keep = m_dir ? up_ok : dn_ok;
            if (!keep) nph = P_BRAKE;
            else if (m_travel + 1 >= TIMEOUT) nph = P_FAULT;
            else if (m_phase == P_RAMP && m_travel + 1 == RAMP_STEP * FULL) nph = P_RUN;
          end
          P_FAULT: if (fault_clr && !up_m && !dn_m) nph = P_IDLE;
          default: nph = P_IDLE;
        endcase
      end
      ntrav = (nph == P_RAMP && m_phase != P_RAMP) ? 0 : m_travel + 1;
      nage  = (nph != m_phase) ? 0 : m_age + 1;
      m_phase  <= nph;
      m_age    <= nage;
      m_travel <= ntrav;
      m_dir    <= ndir;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (state=%0d) at %0t", name, act, exp, dbg_state, $time);
    end
  endtask

  // Every wait goes through here so the model comparison runs on every cycle.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (m_valid) begin
        int e_en, e_brake;
        e_en = 0;
        if (m_phase == P_RUN) e_en = 1;
        else if (m_phase == P_RAMP)
          e_en = ((m_travel % FULL) < (m_travel / RAMP_STEP)) ? 1 : 0;
        e_brake = (m_phase == P_RAMP || m_phase == P_RUN) ? 0 : 1;
        check("model_en", int'(mot_en), e_en);
        check("model_brake", int'(brake), e_brake);
        check("model_fault", int'(fault), (m_phase == P_FAULT) ? 1 : 0);
        check("model_dir", int'(mot_dir), int'(m_dir));
      end
    end
  endtask

  initial begin
    rst = 1'b1; up_m = 1'b1; dn_m = 1'b0;
    up_max = 1'b0; dn_max = 1'b0; fault_clr = 1'b0;

    // Reset with an open request pending.
    tick(2);
    check("reset_en", int'(mot_en), 0);
    check("reset_brake", int'(brake), 1);
    check("reset_fault", int'(fault), 0);
    rst = 1'b0;

    // One edge to leave idle, four braked cycles, then the ramp.
    tick(5);
    check("ramp_dir_up", int'(mot_dir), 1);
    check("ramp_brake_off", int'(brake), 0);
    en_count = 0;
    for (int i = 0; i < 16; i++) begin
      en_count += int'(mot_en);
      tick(1);
    end
    check("ramp_en_pulses", en_count, 7);
    check("run_en", int'(mot_en), 1);

    // Overrun cut at cycle 30 of run, command still held.
    tick(30);
    up_max = 1'b1;
    tick(1);
    check("limit_cut_en", int'(mot_en), 0);
    check("limit_cut_brake", int'(brake), 1);
    tick(4);
    check("limit_idle_brake", int'(brake), 1);
    up_m = 1'b0;
    tick(1);
    up_max = 1'b0;
    tick(2);

    // Reversal from run.
    up_m = 1'b1;
    tick(1 + 4 + 16 + 5);
    up_m = 1'b0; dn_m = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("rev_dead_en", int'(mot_en), 0);
      check("rev_dead_brake", int'(brake), 1);
    end
    tick(1);
    check("rev_dir_down", int'(mot_dir), 0);
    check("rev_brake_off", int'(brake), 0);
    en_count = 0;
    for (int i = 0; i < 8; i++) begin
      en_count += int'(mot_en);
      tick(1);
    end
    check("rev_duty_restart", en_count, 0);

    // Timeout: fault exactly TIMEOUT cycles after ramp entry.
    tick(91);
    check("timeout_not_yet", int'(fault), 0);
    tick(1);
    check("timeout_fault", int'(fault), 1);
    fault_clr = 1'b1;
    tick(3);
    check("fault_held_cmd", int'(fault), 1);
    dn_m = 1'b0;
    tick(1);
    check("fault_cleared", int'(fault), 0);
    fault_clr = 1'b0;

    // Start blocked by the target limit.
    dn_max = 1'b1; dn_m = 1'b1;
    en_count = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      en_count += int'(mot_en) + (1 - int'(brake));
    end
    check("blocked_start", en_count, 0);
    dn_m = 1'b0;
    tick(1);
    dn_max = 1'b0;
    tick(1);

    // Command dropped mid-ramp.
    dn_m = 1'b1;
    tick(1 + 4 + 3);
    dn_m = 1'b0;
    tick(1);
    check("drop_brake", int'(brake), 1);
    tick(6);

    // Contradictory commands during run.
    up_m = 1'b1;
    tick(1 + 4 + 16 + 3);
    dn_m = 1'b1;
    tick(1);
    check("illegal_fault", int'(fault), 1);
    check("illegal_en", int'(mot_en), 0);
    up_m = 1'b0; dn_m = 1'b0; fault_clr = 1'b1;
    tick(1);
    check("illegal_cleared", int'(fault), 0);
    fault_clr = 1'b0;
    tick(2);

    // Reset in the middle of the ramp while the bridge is pulsing.
    up_m = 1'b1;
    tick(1 + 4 + 9);
    check("midramp_en", int'(mot_en), 1);
    rst = 1'b1;
    tick(1);
    check("midreset_en", int'(mot_en), 0);
    check("midreset_brake", int'(brake), 1);
    check("midreset_dir", int'(mot_dir), 0);
    check("midreset_fault", int'(fault), 0);
    rst = 1'b0; up_m = 1'b0;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/garage_motor_driver.md
Name: garage_motor_driver

Overview:
- Downstream stage of the garage door controller: consumes UP_M/DN_M motor requests and drives the physical motor bridge.
- Enforces a braked dead-time before any energise or reversal, applies a PWM soft-start ramp, and cuts the motor on limit overrun.
- Trips a sticky FAULT on travel timeout or on contradictory commands.

Parameters:
- DEAD_TIME, 50, cycles BRAKE is held before energising and after de-energising (>=1)
- RAMP_STEP, 1000, cycles per duty increment during soft start (>=1)
- PWM_BITS, 4, PWM counter width; full duty = 2^PWM_BITS
- TIMEOUT, 1500000, max cycles in RAMP+RUN before FAULT (> ramp length)

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- UP_M  in  1  open request from controller
- DN_M  in  1  close request from controller
- UP_Max  in  1  door fully open limit switch
- DN_Max  in  1  door fully closed limit switch
- FAULT_CLR  in  1  clears FAULT (level)
- MOT_EN  out  1  PWM bridge enable
- MOT_DIR  out  1  1 = up, 0 = down
- BRAKE  out  1  short-brake bridge
- FAULT  out  1  sticky fault flag

Behaviour:
- One clock, CLK. RST is synchronous and active-high. All inputs are synchronous to CLK; the block has no internal synchronisers.
- Reset, taking effect at the first CLK edge with RST=1, from any state including mid-run:
  - state=IDLE; MOT_EN=0, MOT_DIR=0, BRAKE=1, FAULT=0
  - duty=0, all counters 0
- Command decode:
  - cmd_up = UP_M & ~DN_M
  - cmd_dn = DN_M & ~UP_M
  - UP_M & DN_M in any state → FAULT at the next edge. This has the highest priority after RST.
  - A command is valid only if its target limit is not asserted (cmd_up needs UP_Max=0, cmd_dn needs DN_Max=0).
- States: IDLE, BRAKE, RAMP, RUN, FAULT. Outputs are a Moore function of registered state and counters.
- IDLE: BRAKE=1, MOT_EN=0. A valid command → BRAKE, with the dead counter loaded.
- BRAKE: BRAKE=1, MOT_EN=0, held exactly DEAD_TIME cycles. On expiry:
  - valid command present → latch MOT_DIR from that command, duty=0, pwm_cnt=0, travel counter=0, go to RAMP
  - otherwise → IDLE
  - Command changes during BRAKE do not restart the count; only the command at expiry matters.
- RAMP: BRAKE=0.
  - MOT_EN = (pwm_cnt < duty). pwm_cnt is PWM_BITS wide, increments every cycle, wraps.
  - duty is PWM_BITS+1 wide and increments by 1 every RAMP_STEP cycles.
  - When duty = 2^PWM_BITS → RUN, with MOT_EN constantly 1.
- RUN: MOT_EN=1, BRAKE=0.
- Exit from RAMP or RUN → BRAKE, with duty cleared and MOT_EN=0 on the next cycle, when any of these hold:
  - the command in the current direction drops, or the opposite direction is requested (reversal always passes through BRAKE)
  - the limit in the direction of travel asserts (overrun cut). This holds even if the command is still asserted.
- Timeout: the travel counter counts RAMP+RUN cycles. Reaching TIMEOUT → FAULT. If the limit and the timeout hit on the same edge, the limit wins (→ BRAKE).
- FAULT: MOT_EN=0, BRAKE=1, FAULT=1. Exit to IDLE only when FAULT_CLR=1 and UP_M=DN_M=0 on the same edge; otherwise it stays in FAULT.
- MOT_DIR holds its last latched value outside RAMP/RUN.

Test Plan (DEAD_TIME=4, RAMP_STEP=2, PWM_BITS=3, TIMEOUT=100):
- Reset and idle: RST=1 for 2 cycles with UP_M=1 → MOT_EN=0, BRAKE=1, FAULT=0, state IDLE. After release, UP_M still 1 → BRAKE for 4 cycles, then RAMP with MOT_DIR=1.
- Soft start: cmd_up held → duty steps 0..8 every 2 cycles, MOT_EN duty cycle grows monotonically, RUN after 16 RAMP cycles with MOT_EN=1. UP_Max=1 at cycle 30 of RUN → MOT_EN=0, BRAKE=1 on the next cycle, IDLE after 4 cycles.
- Reversal: in RUN up, switch to DN_M=1, UP_M=0 → BRAKE 4 cycles with MOT_EN=0 throughout, then RAMP with MOT_DIR=0 and duty restarting from 0.
- Limit-blocked start: DN_Max=1, DN_M=1 in IDLE → stays IDLE, MOT_EN never 1.
- Timeout: cmd_dn held, DN_Max never asserts → FAULT=1 exactly 100 cycles after RAMP entry. FAULT_CLR=1 with DN_M=1 → stays FAULT. Drop DN_M → IDLE, FAULT=0.
- Illegal input and mid-run reset: UP_M=DN_M=1 during RUN → FAULT next cycle. Separately, RST during RAMP → IDLE, MOT_EN=0, BRAKE=1 from the reset edge.
